// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - 13-bit binary to BCD converter with 4-digit multiplexed seven-segment drive
module ssd_scan_driver #(
   parameter int REFRESH_BITS = 20,
   parameter bit BLANK_LZ     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] value,
   output logic [3:0]  anode,
   output logic [6:0]  segments,
   output logic [15:0] bcd,
   output logic        busy,
   output logic        conv_done
);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t                  state;
   logic [12:0]             shift;
   logic [15:0]             work;
   logic [3:0]              count;
   logic [12:0]             shown_value;
   logic                    valid;
   logic [REFRESH_BITS-1:0] refresh;

   logic [15:0] adj;
   logic [15:0] next_work;
   logic [1:0]  idx;
   logic [3:0]  nibble;
   logic [15:0] upper;
   logic        blank;

   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'b1000000;
         4'd1:    encode = 7'b1111001;
         4'd2:    encode = 7'b0100100;
         4'd3:    encode = 7'b0110000;
         4'd4:    encode = 7'b0011001;
         4'd5:    encode = 7'b0010010;
         4'd6:    encode = 7'b0000010;
         4'd7:    encode = 7'b1111000;
         4'd8:    encode = 7'b0000000;
         4'd9:    encode = 7'b0010000;
         default: encode = 7'b0111111;
      endcase
   endfunction

   // add-3 correction on every BCD nibble that would overflow after the shift
   always_comb begin
      adj = work;
      for (int i = 0; i < 4; i++) begin
         if (work[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
         end
      end
      next_work = {adj[14:0], shift[12]};
   end

   // conversion FSM: capture on change, then one shift-add-3 step per edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shift       <= '0;
         work        <= '0;
         count       <= '0;
         bcd         <= '0;
         shown_value <= '0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         conv_done   <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         case (state)
            IDLE: begin
               if (!valid || (value != shown_value)) begin
                  shift <= value;
                  work  <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= CONVERT;
               end
            end
            CONVERT: begin
               work  <= next_work;
               shift <= {shift[11:0], 1'b0};
               count <= count + 4'd1;
               if (count == 4'd12) begin
                  bcd         <= next_work;
                  shown_value <= value_latch(shown_value);
                  valid       <= 1'b1;
                  conv_done   <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // operand register: holds the value captured at the start of the conversion
   logic [12:0] operand;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         operand <= '0;
      end else if (state == IDLE && (!valid || (value != shown_value))) begin
         operand <= value;
      end
   end

   function automatic logic [12:0] value_latch(input logic [12:0] unused_prev);
      value_latch = operand | (unused_prev & 13'd0);
   endfunction

   // digit selection and leading-zero detection for the current refresh slot
   always_comb begin
      idx    = refresh[REFRESH_BITS-1 -: 2];
      nibble = bcd[{idx, 2'b00} +: 4];
      upper  = bcd >> {idx, 2'b00};
      blank  = BLANK_LZ && (idx != 2'd0) && (upper == 16'd0);
   end

   // free-running refresh counter; anode and segments registered from the same slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh  <= '0;
         anode    <= 4'b1111;
         segments <= 7'b1111111;
      end else begin
         refresh <= refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
         if (!valid) begin
            anode    <= 4'b1111;
            segments <= 7'b1111111;
         end else begin
            anode    <= ~(4'b0001 << idx);
            segments <= blank ? 7'b1111111 : encode(nibble);
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - randomized self-checking bench for ssd_scan_driver against a behavioural model
module tb_ssd_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] value = 13'd0;

   logic [3:0]  anode_a, anode_b;
   logic [6:0]  seg_a, seg_b;
   logic [15:0] bcd_a, bcd_b;
   logic        busy_a, busy_b, done_a, done_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ssd_scan_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .value(value), .anode(anode_a), .segments(seg_a),
      .bcd(bcd_a), .busy(busy_a), .conv_done(done_a)
   );

   ssd_scan_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .value(value), .anode(anode_b), .segments(seg_b),
      .bcd(bcd_b), .busy(busy_b), .conv_done(done_b)
   );

   // behavioural model state
   logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int          m_cnt, m_left, m_op, m_shown;
   logic        m_valid, m_done;
   logic [15:0] m_bcd;
   logic [3:0]  m_an;
   logic [6:0]  m_seg_lz, m_seg_all;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] show(input logic [15:0] b, input int d, input bit lz);
      int digit;
      digit = (b >> (4 * d)) & 15;
      if (lz && d > 0 && (b >> (4 * d)) == 0) return 7'b1111111;
      if (digit > 9) return 7'b0111111;
      return seg_tab[digit];
   endfunction

   always @(posedge clk or posedge rst) begin
      int d;
      if (rst) begin
         m_cnt = 0; m_left = 0; m_op = 0; m_shown = 0;
         m_valid = 1'b0; m_done = 1'b0; m_bcd = 16'h0;
         m_an = 4'b1111; m_seg_lz = 7'b1111111; m_seg_all = 7'b1111111;
      end else begin
         d = m_cnt / 4;
         if (m_valid) begin
            m_an      = ~(4'(1 << d));
            m_seg_lz  = show(m_bcd, d, 1'b1);
            m_seg_all = show(m_bcd, d, 1'b0);
         end else begin
            m_an = 4'b1111; m_seg_lz = 7'b1111111; m_seg_all = 7'b1111111;
         end
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_bcd = to_bcd(m_op); m_shown = m_op; m_valid = 1'b1; m_done = 1'b1;
            end
         end else if (!m_valid || int'(value) != m_shown) begin
            m_op = int'(value); m_left = 13;
         end
         m_cnt = (m_cnt + 1) % 16;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("anode_lz",  32'(anode_a), 32'(m_an));
      check("seg_lz",    32'(seg_a),   32'(m_seg_lz));
      check("anode_all", 32'(anode_b), 32'(m_an));
      check("seg_all",   32'(seg_b),   32'(m_seg_all));
      check("bcd",       32'(bcd_a),   32'(m_bcd));
      check("bcd_nb",    32'(bcd_b),   32'(m_bcd));
      check("busy",      32'(busy_a),  32'(m_left > 0));
      check("conv_done", 32'(done_a),  32'(m_done));
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_done(input int budget, output int edges, output int busy_cycles);
      edges = 0; busy_cycles = 0;
      do begin
         step();
         edges++;
         if (busy_a) busy_cycles++;
      end while (!done_a && edges < budget);
      if (!done_a) check("timeout", 32'(done_a), 32'd1);
   endtask

   initial begin
      int edges, bc, pulses, busy_seen;

      // reset
      value = 13'd0;
      #1 rst = 1'b1;
      #3;
      check("rst_anode", 32'(anode_a), 32'hF);
      check("rst_seg",   32'(seg_a),   32'h7F);
      check("rst_bcd",   32'(bcd_a),   32'h0);
      check("rst_busy",  32'(busy_a),  32'h0);
      check("rst_done",  32'(done_a),  32'h0);
      step(); step();
      rst = 1'b0;

      // first conversion of 0
      wait_done(20, edges, bc);
      check("lat_zero", 32'(edges), 32'd14);
      check("bcd_zero", 32'(bcd_a), 32'h0000);
      repeat (20) step();

      // full scale
      value = 13'd8191;
      wait_done(20, edges, bc);
      check("lat_8191",  32'(edges), 32'd14);
      check("busy_8191", 32'(bc),    32'd13);
      check("bcd_8191",  32'(bcd_a), 32'h8191);
      repeat (20) step();

      // change during conversion is deferred
      value = 13'd1234;
      repeat (5) step();
      value = 13'd4321;
      wait_done(20, edges, bc);
      check("lat_1234",  32'(edges), 32'd9);
      check("bcd_1234",  32'(bcd_a), 32'h1234);
      check("idle_gap",  32'(busy_a), 32'd0);
      wait_done(20, edges, bc);
      check("lat_4321",  32'(edges), 32'd14);
      check("bcd_4321",  32'(bcd_a), 32'h4321);
      repeat (20) step();

      // single digit, blanking versus all digits
      value = 13'd7;
      wait_done(20, edges, bc);
      check("bcd_7", 32'(bcd_a), 32'h0007);
      repeat (20) step();

      // reset in the middle of a conversion
      value = 13'd999;
      repeat (6) step();
      rst = 1'b1;
      #1;
      check("mid_rst_anode", 32'(anode_a), 32'hF);
      check("mid_rst_seg",   32'(seg_a),   32'h7F);
      check("mid_rst_busy",  32'(busy_a),  32'h0);
      check("mid_rst_bcd",   32'(bcd_a),   32'h0);
      step();
      rst = 1'b0;
      wait_done(20, edges, bc);
      check("lat_999", 32'(edges), 32'd14);
      check("bcd_999", 32'(bcd_a), 32'h0999);

      // stable value causes no further conversions
      value = 13'd42;
      wait_done(20, edges, bc);
      pulses = 0; busy_seen = 0;
      repeat (200) begin
         step();
         if (done_a) pulses++;
         if (busy_a) busy_seen++;
      end
      check("hold_pulses", 32'(pulses),    32'd0);
      check("hold_busy",   32'(busy_seen), 32'd0);
      check("hold_bcd",    32'(bcd_a),     32'h0042);

      // random values with random hold times
      repeat (60) begin
         value = 13'($urandom_range(0, 8191));
         repeat ($urandom_range(0, 30)) step();
      end
      repeat (40) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
